// File: rtl/fifo_packer_pkg.sv
// Shared types and default sizing for the FIFO-to-wide-beat packer.
package fifo_packer_pkg;

  localparam int DEFAULT_WIDTH   = 8;
  localparam int DEFAULT_RATIO   = 4;
  localparam int DEFAULT_TIMEOUT = 16;

  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    SEND    = 1'b1
  } state_t;

endpackage

// File: rtl/fifo_packer_ff.sv
// Enable flip-flop used for each packed lane; synchronous active-low reset.
module fifo_packer_ff #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fifo_packer.sv
// Packs RATIO words from an upstream FIFO into one wide output beat,
// emitting a partial beat on flush or after an idle timeout.
module fifo_packer
  import fifo_packer_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int RATIO   = DEFAULT_RATIO,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       fifo_empty,
  input  logic [WIDTH-1:0]           fifo_data,
  output logic                       fifo_pop,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH*RATIO-1:0]     out_data,
  output logic [$clog2(RATIO+1)-1:0] out_count
);

  localparam int CW = $clog2(RATIO + 1);
  localparam int IW = $clog2(TIMEOUT);

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic [CW-1:0] cnt_pop;
  logic [IW-1:0] idle;
  logic [IW-1:0] idle_next;
  logic          pop;
  logic          handshake;
  logic [RATIO-1:0] lane_en;
  logic [WIDTH-1:0] lane_d;

  // Popping is only legal while collecting; reset gates it combinationally.
  assign pop       = (state == COLLECT) && !fifo_empty && rst;
  assign fifo_pop  = pop;
  assign handshake = (state == SEND) && out_ready;
  assign cnt_pop   = cnt + CW'(pop);

  assign out_valid = (state == SEND);
  assign out_count = cnt;

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    idle_next  = idle;
    case (state)
      COLLECT: begin
        cnt_next = cnt_pop;
        if (pop || cnt == '0) begin
          idle_next = '0;
        end else if (idle < IW'(TIMEOUT - 1)) begin
          idle_next = idle + IW'(1);
        end
        // A full beat, a flush with data, or an expired idle count all close the beat.
        if (cnt_pop == CW'(RATIO)) begin
          state_next = SEND;
        end else if (flush && cnt_pop != '0) begin
          state_next = SEND;
        end else if (!pop && cnt != '0 && idle_next == IW'(TIMEOUT - 1)) begin
          state_next = SEND;
        end
      end
      SEND: begin
        if (out_ready) begin
          state_next = COLLECT;
          cnt_next   = '0;
          idle_next  = '0;
        end
      end
      default: begin
        state_next = COLLECT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= COLLECT;
      cnt   <= '0;
      idle  <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      idle  <= idle_next;
    end
  end

  // On handshake every lane loads zero so unused lanes of the next beat read as zero.
  assign lane_d = handshake ? '0 : fifo_data;

  for (genvar k = 0; k < RATIO; k++) begin : g_lane
    assign lane_en[k] = (pop && cnt == CW'(k)) || handshake;

    fifo_packer_ff #(
      .WIDTH(WIDTH)
    ) u_lane (
      .clk(clk),
      .rst(rst),
      .en (lane_en[k]),
      .d  (lane_d),
      .q  (out_data[k*WIDTH +: WIDTH])
    );
  end

endmodule
